reservation_station_mc: RTL and testbench

Parametrised multi-channel successor to the single-unit reservation station. Accepts up to ISSUE_W instructions per cycle and snoops CDB_W common-data-bus channels for operand wakeup. Dispatches the oldest operand-ready entry to its execution unit each cycle. Supports speculative-tag flush and commit.

---
 rtl/reservation_station_mc_pkg.sv | 45 ++++
 rtl/rs_age_select.sv | 53 +++++
 rtl/reservation_station_mc.sv | 159 +++++++++++++++
 tb/tb_reservation_station_mc.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_mc_pkg.sv
// Shared types for the multi-channel reservation station.
//   station_record_t : one instruction slot (operands, tags, speculation bit)
//   instr_name_e     : opcode carried through to the execution unit
//   record_ready     : operand-ready test shared by the station and its users
package reservation_station_mc_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned REG_W_DEFAULT = 6;

  typedef enum logic [3:0] {
    InstrNop,
    InstrAdd,
    InstrSub,
    InstrAnd,
    InstrOr,
    InstrXor,
    InstrSll,
    InstrSrl,
    InstrLw,
    InstrSw,
    InstrBeq,
    InstrJal
  } instr_name_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]  data_1;
    logic [XLEN_DEFAULT-1:0]  data_2;
    logic [XLEN_DEFAULT-1:0]  address;
    logic [XLEN_DEFAULT-1:0]  imm;
    logic [REG_W_DEFAULT-1:0] src_1;
    logic [REG_W_DEFAULT-1:0] src_2;
    logic [REG_W_DEFAULT-1:0] rrn;
    logic                     valid_1;
    logic                     valid_2;
    logic                     tag;
    logic                     skip;
    instr_name_e              instr_name;
  } station_record_t;

  // skip marks instructions that do not wait on register operands.
  function automatic logic record_ready(input station_record_t r);
    return r.skip || (r.valid_1 && r.valid_2);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix with oldest-ready one-hot selection.
//   clk_i, reset_i : clock, synchronous active-high reset (clears the matrix)
//   alloc_i        : slots written this cycle; lower index is older among them
//   ready_i        : slots eligible for selection (must be valid slots)
//   sel_o          : one-hot oldest ready slot, zero when none is ready
module rs_age_select #(
  parameter int unsigned SIZE = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [SIZE-1:0] alloc_i,
  input  logic [SIZE-1:0] ready_i,
  output logic [SIZE-1:0] sel_o
);

  // older_q[i][j] = 1: slot i is older than slot j. Rows of free slots are stale
  // and are rewritten on allocation, so no per-slot valid is needed here.
  logic [SIZE-1:0][SIZE-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < SIZE; i++) begin
      if (alloc_i[i]) begin
        for (int j = 0; j < SIZE; j++) begin
          older_d[i][j] = alloc_i[j] && (i < j);
          if (!alloc_i[j]) begin
            older_d[j][i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_o = ready_i;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (j != i && ready_i[j] && older_q[j][i]) begin
          sel_o[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/reservation_station_mc.sv
// Multi-channel reservation station.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   delete_tag_i            : flush all speculative (tag=1) entries and issues
//   clear_tag_i             : commit speculation, clear tag everywhere
//   issue_valid_i/_ready_o  : ISSUE_W-wide all-or-nothing issue handshake
//   issue_rec_i             : per-channel incoming records
//   cdb_valid/rrn/data_i    : CDB_W result broadcast channels
//   exec_valid_o/_ready_i   : dispatch handshake, exec_rec_o is the oldest ready entry
//   free_count_o            : registered number of free slots
module reservation_station_mc
  import reservation_station_mc_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned SIZE    = 16,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned CDB_W   = 2,
  parameter int unsigned REG_W   = REG_W_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              delete_tag_i,
  input  logic                              clear_tag_i,
  input  logic            [ISSUE_W-1:0]     issue_valid_i,
  output logic                              issue_ready_o,
  input  station_record_t [ISSUE_W-1:0]     issue_rec_i,
  input  logic            [CDB_W-1:0]       cdb_valid_i,
  input  logic            [CDB_W-1:0][REG_W-1:0] cdb_rrn_i,
  input  logic            [CDB_W-1:0][XLEN-1:0]  cdb_data_i,
  output logic                              exec_valid_o,
  input  logic                              exec_ready_i,
  output station_record_t                   exec_rec_o,
  output logic            [$clog2(SIZE):0]  free_count_o
);

  localparam int unsigned CntW = $clog2(SIZE) + 1;

  station_record_t [SIZE-1:0] rec_q, rec_d;
  logic [SIZE-1:0]    valid_q, valid_d;
  logic [SIZE-1:0]    alloc_mask, ready, sel;
  logic [CntW-1:0]    free_count_q, free_count_d;
  logic               issue_ready_q, issue_ready_d;
  logic [ISSUE_W-1:0] take;
  logic               fire;

  // Operand capture from the CDB; descending scan so the lowest channel wins.
  function automatic station_record_t snoop(
    input station_record_t                   r,
    input logic [CDB_W-1:0]                  v,
    input logic [CDB_W-1:0][REG_W-1:0]       rrn,
    input logic [CDB_W-1:0][XLEN-1:0]        data
  );
    station_record_t o;
    o = r;
    for (int c = int'(CDB_W) - 1; c >= 0; c--) begin
      if (v[c] && !r.valid_1 && (rrn[c] == r.src_1)) begin
        o.data_1  = data[c];
        o.valid_1 = 1'b1;
      end
      if (v[c] && !r.valid_2 && (rrn[c] == r.src_2)) begin
        o.data_2  = data[c];
        o.valid_2 = 1'b1;
      end
    end
    return o;
  endfunction

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      take[k] = issue_valid_i[k] && issue_ready_q && !(delete_tag_i && issue_rec_i[k].tag);
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      ready[i] = valid_q[i] && record_ready(rec_q[i]);
    end
  end

  rs_age_select #(
    .SIZE (SIZE)
  ) u_age_select (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .alloc_i (alloc_mask),
    .ready_i (ready),
    .sel_o   (sel)
  );

  always_comb begin
    exec_rec_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (sel[i]) begin
        exec_rec_o = rec_q[i];
      end
    end
  end

  assign exec_valid_o = (|sel) && !(delete_tag_i && exec_rec_o.tag);
  assign fire         = exec_valid_o && exec_ready_i;

  // Slot update. Channel k claims the free slot of rank k, so a channel's slot
  // never depends on which other channels are valid this cycle.
  always_comb begin
    int rank;
    rank       = 0;
    valid_d    = valid_q;
    rec_d      = rec_q;
    alloc_mask = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (valid_q[i]) begin
        rec_d[i] = snoop(rec_q[i], cdb_valid_i, cdb_rrn_i, cdb_data_i);
        if (clear_tag_i) begin
          rec_d[i].tag = 1'b0;
        end
        if ((fire && sel[i]) || (delete_tag_i && rec_q[i].tag)) begin
          valid_d[i] = 1'b0;
        end
      end else begin
        for (int k = 0; k < ISSUE_W; k++) begin
          if (rank == k && take[k]) begin
            rec_d[i] = snoop(issue_rec_i[k], cdb_valid_i, cdb_rrn_i, cdb_data_i);
            if (clear_tag_i) begin
              rec_d[i].tag = 1'b0;
            end
            valid_d[i]    = 1'b1;
            alloc_mask[i] = 1'b1;
          end
        end
        rank++;
      end
    end
  end

  // Counting the next free set directly equals free + freed - allocated.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < SIZE; i++) begin
      free_count_d = free_count_d + CntW'(!valid_d[i]);
    end
    issue_ready_d = (free_count_d >= CntW'(ISSUE_W));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q       <= '0;
      free_count_q  <= CntW'(SIZE);
      issue_ready_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rec_q         <= rec_d;
      free_count_q  <= free_count_d;
      issue_ready_q <= issue_ready_d;
    end
  end

  assign issue_ready_o = issue_ready_q;
  assign free_count_o  = free_count_q;

endmodule

// File: tb/tb_reservation_station_mc.sv
module tb_reservation_station_mc;
  import reservation_station_mc_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  delete_tag;
  logic                  clear_tag;
  logic [1:0]            issue_valid;
  logic                  issue_ready;
  station_record_t [1:0] issue_rec;
  logic [1:0]            cdb_valid;
  logic [1:0][5:0]       cdb_rrn;
  logic [1:0][31:0]      cdb_data;
  logic                  exec_valid;
  logic                  exec_ready;
  station_record_t       exec_rec;
  logic [4:0]            free_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reservation_station_mc #(
    .XLEN    (32),
    .SIZE    (16),
    .ISSUE_W (2),
    .CDB_W   (2),
    .REG_W   (6)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .delete_tag_i (delete_tag),
    .clear_tag_i  (clear_tag),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .issue_rec_i  (issue_rec),
    .cdb_valid_i  (cdb_valid),
    .cdb_rrn_i    (cdb_rrn),
    .cdb_data_i   (cdb_data),
    .exec_valid_o (exec_valid),
    .exec_ready_i (exec_ready),
    .exec_rec_o   (exec_rec),
    .free_count_o (free_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic station_record_t mk(input int rrn, input int s1, input int v1,
                                         input logic [31:0] d1, input int s2, input int v2,
                                         input logic [31:0] d2, input int tag);
    station_record_t r;
    r            = '0;
    r.rrn        = 6'(rrn);
    r.src_1      = 6'(s1);
    r.valid_1    = (v1 != 0);
    r.data_1     = d1;
    r.src_2      = 6'(s2);
    r.valid_2    = (v2 != 0);
    r.data_2     = d2;
    r.tag        = (tag != 0);
    r.instr_name = InstrAdd;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; delete_tag = 1'b0; clear_tag = 1'b0; issue_valid = '0;
    issue_rec = '0; cdb_valid = '0; cdb_rrn = '0; cdb_data = '0; exec_ready = 1'b0;

    // Reset state
    cyc();
    @(negedge clk);
    check_eq("rst_free", 32'(free_count), 16);
    check_eq("rst_issue_ready", 32'(issue_ready), 0);
    check_eq("rst_exec_valid", 32'(exec_valid), 0);
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check_eq("post_rst_ready", 32'(issue_ready), 1);

    // Two ready issues, dispatched in channel order
    issue_valid  = 2'b11;
    issue_rec[0] = mk(5, 1, 1, 32'h11, 2, 1, 32'h12, 0);
    issue_rec[1] = mk(6, 1, 1, 32'h21, 2, 1, 32'h22, 0);
    exec_ready   = 1'b1;
    cyc();
    issue_valid = '0;
    @(negedge clk);
    check_eq("p1_valid_a", 32'(exec_valid), 1);
    check_eq("p1_rrn_a", 32'(exec_rec.rrn), 5);
    check_eq("p1_data_a", exec_rec.data_1, 32'h11);
    check_eq("p1_free14", 32'(free_count), 14);
    cyc();
    @(negedge clk);
    check_eq("p1_rrn_b", 32'(exec_rec.rrn), 6);
    check_eq("p1_free15", 32'(free_count), 15);
    cyc();
    @(negedge clk);
    check_eq("p1_empty", 32'(exec_valid), 0);
    check_eq("p1_free16", 32'(free_count), 16);

    // CDB wakeup on channel 1
    issue_valid  = 2'b01;
    issue_rec[0] = mk(7, 9, 0, 32'h0, 2, 1, 32'h22, 0);
    cyc();
    issue_valid = '0;
    @(negedge clk);
    check_eq("p2_wait0", 32'(exec_valid), 0);
    check_eq("p2_free15", 32'(free_count), 15);
    cyc();
    cdb_valid = 2'b10; cdb_rrn[1] = 6'd9; cdb_data[1] = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("p2_wait1", 32'(exec_valid), 0);
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p2_woken", 32'(exec_valid), 1);
    check_eq("p2_rrn", 32'(exec_rec.rrn), 7);
    check_eq("p2_data1", exec_rec.data_1, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    check_eq("p2_done", 32'(exec_valid), 0);
    check_eq("p2_free16", 32'(free_count), 16);

    // Same-cycle bypass, both CDB channels match: channel 0 wins
    issue_valid  = 2'b01;
    issue_rec[0] = mk(8, 1, 1, 32'h1, 3, 0, 32'h0, 0);
    cdb_valid = 2'b11; cdb_rrn[0] = 6'd3; cdb_data[0] = 32'h42;
    cdb_rrn[1] = 6'd3; cdb_data[1] = 32'h99;
    cyc();
    issue_valid = '0; cdb_valid = '0;
    @(negedge clk);
    check_eq("p3_ready", 32'(exec_valid), 1);
    check_eq("p3_rrn", 32'(exec_rec.rrn), 8);
    check_eq("p3_data2", exec_rec.data_2, 32'h42);
    cyc();
    @(negedge clk);
    check_eq("p3_done", 32'(exec_valid), 0);

    // Fill 15 entries: rrn k, src_1 = 20+k unready, tag = k odd
    exec_ready = 1'b0;
    for (int p = 0; p < 7; p++) begin
      issue_valid  = 2'b11;
      issue_rec[0] = mk(2 * p, 20 + 2 * p, 0, 32'h0, 2, 1, 32'h5, 0);
      issue_rec[1] = mk(2 * p + 1, 21 + 2 * p, 0, 32'h0, 2, 1, 32'h5, 1);
      cyc();
    end
    issue_valid  = 2'b01;
    issue_rec[0] = mk(14, 34, 0, 32'h0, 2, 1, 32'h5, 0);
    cyc();
    // Held request while not ready must be ignored
    issue_valid  = 2'b11;
    issue_rec[0] = mk(40, 1, 1, 32'h1, 2, 1, 32'h2, 0);
    issue_rec[1] = mk(41, 1, 1, 32'h1, 2, 1, 32'h2, 0);
    @(negedge clk);
    check_eq("p4_free1", 32'(free_count), 1);
    check_eq("p4_not_ready", 32'(issue_ready), 0);
    cyc();
    @(negedge clk);
    check_eq("p4_hold_free", 32'(free_count), 1);
    check_eq("p4_hold_noexec", 32'(exec_valid), 0);
    issue_valid = '0;
    cdb_valid = 2'b01; cdb_rrn[0] = 6'd20; cdb_data[0] = 32'h77;
    exec_ready = 1'b1;
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p4_wake_valid", 32'(exec_valid), 1);
    check_eq("p4_wake_rrn", 32'(exec_rec.rrn), 0);
    check_eq("p4_still_full", 32'(issue_ready), 0);
    cyc();
    @(negedge clk);
    check_eq("p4_free2", 32'(free_count), 2);
    check_eq("p4_ready_again", 32'(issue_ready), 1);

    // Flush: tagged entry selected, then delete_tag masks it and frees all tagged
    exec_ready = 1'b0;
    cdb_valid = 2'b01; cdb_rrn[0] = 6'd21; cdb_data[0] = 32'h88;
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p5_tagged_shown", 32'(exec_rec.rrn), 1);
    delete_tag   = 1'b1;
    issue_valid  = 2'b11;
    issue_rec[0] = mk(50, 1, 1, 32'h1, 2, 1, 32'h2, 1);
    issue_rec[1] = mk(51, 60, 0, 32'h0, 2, 1, 32'h2, 0);
    #1;
    check_eq("p5_flush_mask", 32'(exec_valid), 0);
    cyc();
    delete_tag = 1'b0; issue_valid = '0;
    @(negedge clk);
    check_eq("p5_free8", 32'(free_count), 8);
    check_eq("p5_no_tagged_issue", 32'(exec_valid), 0);

    // Age: younger ready first, then older overtakes it
    cdb_valid = 2'b01; cdb_rrn[0] = 6'd60; cdb_data[0] = 32'h60;
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p6_young", 32'(exec_rec.rrn), 51);
    cdb_valid = 2'b01; cdb_rrn[0] = 6'd22; cdb_data[0] = 32'h22;
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p6_old", 32'(exec_rec.rrn), 2);
    exec_ready = 1'b1;
    cyc();
    @(negedge clk);
    check_eq("p6_then_young", 32'(exec_rec.rrn), 51);
    check_eq("p6_free9", 32'(free_count), 9);
    cyc();
    @(negedge clk);
    check_eq("p6_empty", 32'(exec_valid), 0);
    check_eq("p6_free10", 32'(free_count), 10);

    // clear_tag on issuing records, then on stored entries; delete frees nothing
    issue_valid  = 2'b11;
    clear_tag    = 1'b1;
    issue_rec[0] = mk(70, 80, 0, 32'h0, 2, 1, 32'h2, 1);
    issue_rec[1] = mk(71, 81, 0, 32'h0, 2, 1, 32'h2, 1);
    cyc();
    clear_tag    = 1'b0;
    issue_rec[0] = mk(72, 82, 0, 32'h0, 2, 1, 32'h2, 1);
    issue_rec[1] = mk(73, 83, 0, 32'h0, 2, 1, 32'h2, 1);
    cyc();
    issue_valid = '0;
    clear_tag   = 1'b1;
    @(negedge clk);
    check_eq("p7_free6", 32'(free_count), 6);
    cyc();
    clear_tag  = 1'b0;
    delete_tag = 1'b1;
    cyc();
    delete_tag = 1'b0;
    @(negedge clk);
    check_eq("p7_committed", 32'(free_count), 6);

    // Reset with a dispatch pending
    cdb_valid = 2'b01; cdb_rrn[0] = 6'd80; cdb_data[0] = 32'h80;
    cyc();
    cdb_valid = '0;
    @(negedge clk);
    check_eq("p8_pending", 32'(exec_valid), 1);
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check_eq("p8_rst_free", 32'(free_count), 16);
    check_eq("p8_rst_exec", 32'(exec_valid), 0);
    check_eq("p8_rst_ready", 32'(issue_ready), 0);
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check_eq("p8_ready", 32'(issue_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
